inst_axi_rd_bridge: RTL and testbench
=====================================

Name: inst_axi_rd_bridge

Overview:
- Downstream neighbour of the instruction cache: a slave on the cache's SRAM-like miss port (req/addr_ok/data_ok) and a master on the AXI4 read-address (AR) and read-data (R) channels.
- Converts each accepted cache-miss read into exactly one single-beat AXI read and returns the word with a data_ok pulse.
- Read-only. The instruction side never writes.
- One outstanding transaction at a time.

Parameters:
- ID_WIDTH, 4, width of arid/rid.
- AR_ID, 0, constant value driven on arid.
- ADDR_WIDTH, 32, address width on both sides.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  cache read request, held until addr_ok.
- wr  in  1  write flag. Must be 0; requests with wr=1 are never accepted.
- size  in  2  0=byte, 1=half, 2=word.
- addr  in  ADDR_WIDTH  request address.
- rdata  out  32  returned word, combinational from the R channel.
- addr_ok  out  1  request-accept pulse.
- data_ok  out  1  data-return pulse.
- arid  out  ID_WIDTH  constant AR_ID.
- araddr  out  ADDR_WIDTH  registered request address.
- arlen  out  8  constant 0.
- arsize  out  3  {1'b0,size}, latched with the address.
- arburst  out  2  constant 2'b01 (INCR).
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  ID_WIDTH  ignored.
- rdata_axi  in  32  R data.
- rresp  in  2  R response.
- rlast  in  1  ignored (single-beat only).
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- FSM has three states: IDLE, ADDR, DATA. On reset the FSM is in IDLE.
- Reset values: arvalid=0, rready=0, addr_ok=0, data_ok=0, araddr=0, arsize=0.
- IDLE:
  - If req=1 and wr=0: latch addr into araddr and size into arsize, set arvalid=1 on the next edge, go to ADDR.
  - If wr=1 or req=0: stay in IDLE.
- ADDR:
  - arvalid=1. araddr and arsize are held stable.
  - addr_ok = arvalid & arready, combinational, one cycle.
  - On that handshake: arvalid<=0, go to DATA.
  - If arready stays low, wait indefinitely.
- DATA:
  - rready=1, combinational from state.
  - data_ok = rvalid & rready, combinational, one cycle.
  - rdata = rdata_axi passthrough, valid only while data_ok=1 (the cache writes its line in that cycle).
  - On data_ok: go to IDLE.
- Latency: minimum 3 cycles from req to data_ok (req edge, AR handshake, R beat). addr_ok never coincides with data_ok.
- Back-to-back: the next request is sampled in IDLE on the cycle after data_ok. There is no IDLE->ADDR bypass.
- Address changes on addr after latching have no effect.
- rvalid while in IDLE or ADDR: rready=0, so the beat is not consumed.
- rresp≠OKAY: data is still returned with data_ok; the response is otherwise ignored (see optional feature).
- Reset asserted mid-operation: immediate asynchronous return to IDLE and all outputs to reset values. The whole SoC resets together, so dropping arvalid mid-handshake is accepted.

Optional Feature:
- Macro: INST_AXI_RD_BRIDGE_RRESP_ERR_EN.
- Defined:
  - Adds output port bus_err (1 bit), equal to data_ok & (rresp!=2'b00).
  - Adds a sticky output err_seen, which sets on any bus_err and clears only on rst.
- Undefined: neither port exists and rresp is unused.

Decomposition:
- Shared package holds:
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00, SIZE_WORD=3'b010.
  - The FSM state encoding typedef (IDLE/ADDR/DATA).
- The package is reused by the future data-side bridge.
- No sub-module: the block is a single FSM plus AR holding registers.

Test Plan:
- Basic read: req=1, addr=0x1FC00010, size=2, arready=1 immediately, rvalid two cycles later with rdata_axi=0x3C08BFC0 -> araddr=0x1FC00010, arsize=3'b010, arlen=0, arburst=01, one addr_ok pulse, then data_ok=1 with rdata=0x3C08BFC0, FSM back in IDLE.
- Slow AR: arready held low 5 cycles -> arvalid held high and araddr stable for all 5 cycles; addr_ok only on the handshake cycle.
- Early rvalid: rvalid=1 while in ADDR -> rready=0 and no data_ok until the FSM reaches DATA.
- Write rejected: req=1, wr=1 for 10 cycles -> arvalid, addr_ok and data_ok all stay 0.
- Reset mid-ADDR: assert rst while arvalid=1, between clock edges -> arvalid drops without waiting for a clock edge; after release, a new req=1 addr=0x00000040 completes normally.
- Error response (macro defined): rresp=2'b10 with rvalid -> data_ok=1, bus_err=1 for one cycle, err_seen stays 1 through later OKAY reads until rst.

Source files
------------

// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI read-side constants and bridge FSM encoding.
// Used by the instruction-side read bridge and the data-side bridge.
package inst_axi_rd_bridge_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_WORD  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } bridge_state_e;

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Instruction-cache miss port to AXI4 single-beat read bridge.
// Optional macro INST_AXI_RD_BRIDGE_RRESP_ERR_EN adds bus_err / err_seen outputs.
//
// state | meaning
// IDLE  | waiting for a cache read request (wr=0)
// ADDR  | arvalid high, address/size held until arready
// DATA  | rready high, waiting for the single R beat
module inst_axi_rd_bridge
    import inst_axi_rd_bridge_pkg::*;
#(
    parameter int                  ID_WIDTH   = 4,
    parameter logic [ID_WIDTH-1:0] AR_ID      = '0,
    parameter int                  ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  wr,
    input  logic [1:0]            size,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [31:0]           rdata,
    output logic                  addr_ok,
    output logic                  data_ok,
    output logic [ID_WIDTH-1:0]   arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_WIDTH-1:0]   rid,
    input  logic [31:0]           rdata_axi,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
`ifdef INST_AXI_RD_BRIDGE_RRESP_ERR_EN
    output logic                  bus_err,
    output logic                  err_seen,
`endif
    output logic                  rready
);

    bridge_state_e         state_q,   state_d;
    logic [ADDR_WIDTH-1:0] araddr_q,  araddr_d;
    logic [2:0]            arsize_q,  arsize_d;
    logic                  arvalid_q, arvalid_d;

    // Single-beat reads only: fixed ID, length and burst type.
    assign arid    = AR_ID;
    assign arlen   = 8'd0;
    assign arburst = BURST_INCR;
    assign araddr  = araddr_q;
    assign arsize  = arsize_q;
    assign arvalid = arvalid_q;
    assign rdata   = rdata_axi;

    // Next-state, AR holding registers and handshake outputs.
    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        arvalid_d = arvalid_q;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        rready    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && !wr) begin
                    araddr_d  = addr;
                    arsize_d  = {1'b0, size};
                    arvalid_d = 1'b1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                addr_ok = arvalid_q & arready;
                if (addr_ok) begin
                    arvalid_d = 1'b0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                rready  = 1'b1;
                data_ok = rvalid;
                if (rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and AR register update; reset drops arvalid immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            araddr_q  <= '0;
            arsize_q  <= '0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            arvalid_q <= arvalid_d;
        end
    end

`ifdef INST_AXI_RD_BRIDGE_RRESP_ERR_EN
    logic err_seen_q, err_seen_d;

    assign bus_err  = data_ok & (rresp != RESP_OKAY);
    assign err_seen = err_seen_q;

    // Sticky error flag, cleared only by reset.
    always_comb begin
        err_seen_d = err_seen_q | bus_err;
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_seen_q <= 1'b0;
        end else begin
            err_seen_q <= err_seen_d;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{rid, rlast};
`else
    logic unused_ok;
    assign unused_ok = ^{rid, rlast, rresp};
`endif

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed self-checking bench for inst_axi_rd_bridge.
// Build with INST_AXI_RD_BRIDGE_RRESP_ERR_EN to also exercise bus_err / err_seen.
module tb_inst_axi_rd_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata_axi;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
`ifdef INST_AXI_RD_BRIDGE_RRESP_ERR_EN
    logic        bus_err;
    logic        err_seen;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_axi_rd_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .rdata     (rdata),
        .addr_ok   (addr_ok),
        .data_ok   (data_ok),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata_axi (rdata_axi),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
`ifdef INST_AXI_RD_BRIDGE_RRESP_ERR_EN
        .bus_err   (bus_err),
        .err_seen  (err_seen),
`endif
        .rready    (rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0;
        arready = 1'b0; rid = 4'h5; rdata_axi = '0; rresp = 2'b00;
        rlast = 1'b1; rvalid = 1'b0;
        #12;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready",  rready,  1'b0);
        chk("rst_addr_ok", addr_ok, 1'b0);
        chk("rst_data_ok", data_ok, 1'b0);
        chk("rst_araddr",  araddr,  32'h0);
        chk("rst_arsize",  arsize,  3'b000);
        chk("const_arid",  arid,    4'h0);
        chk("const_arlen", arlen,   8'h00);
        chk("const_arburst", arburst, 2'b01);
        rst = 1'b0;
        tick();

        // Basic read
        req = 1'b1; addr = 32'h1FC0_0010; size = 2'd2; arready = 1'b1;
        #1;
        chk("basic_idle_arvalid", arvalid, 1'b0);
        tick();
        req = 1'b0; addr = 32'hAAAA_5555; #1;
        chk("basic_arvalid", arvalid, 1'b1);
        chk("basic_araddr",  araddr,  32'h1FC0_0010);
        chk("basic_arsize",  arsize,  3'b010);
        chk("basic_addr_ok", addr_ok, 1'b1);
        chk("basic_no_data_ok_in_addr", data_ok, 1'b0);
        tick();
        arready = 1'b0; #1;
        chk("basic_data_rready",  rready,  1'b1);
        chk("basic_data_arvalid", arvalid, 1'b0);
        chk("basic_data_addr_ok", addr_ok, 1'b0);
        chk("basic_wait_data_ok", data_ok, 1'b0);
        tick();
        rvalid = 1'b1; rdata_axi = 32'h3C08_BFC0; #1;
        chk("basic_data_ok", data_ok, 1'b1);
        chk("basic_rdata",   rdata,   32'h3C08_BFC0);
        chk("basic_araddr_held", araddr, 32'h1FC0_0010);
        tick();
        rvalid = 1'b0; #1;
        chk("basic_back_idle_rready", rready, 1'b0);
        chk("basic_back_idle_data_ok", data_ok, 1'b0);

        // Slow AR with early rvalid
        req = 1'b1; addr = 32'h0000_1004; size = 2'd1; arready = 1'b0;
        tick();
        req = 1'b0; addr = 32'h0; rvalid = 1'b1; rdata_axi = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("slow_arvalid", arvalid, 1'b1);
            chk("slow_araddr",  araddr,  32'h0000_1004);
            chk("slow_arsize",  arsize,  3'b001);
            chk("slow_addr_ok", addr_ok, 1'b0);
            chk("early_rready", rready,  1'b0);
            chk("early_data_ok", data_ok, 1'b0);
            tick();
        end
        arready = 1'b1; #1;
        chk("slow_hs_addr_ok", addr_ok, 1'b1);
        chk("slow_hs_no_data_ok", data_ok, 1'b0);
        tick();
        arready = 1'b0; #1;
        chk("early_data_ok_in_data", data_ok, 1'b1);
        chk("early_rdata", rdata, 32'hDEAD_BEEF);
        chk("early_addr_ok_low", addr_ok, 1'b0);
        tick();
        rvalid = 1'b0; #1;
        chk("early_back_idle", rready, 1'b0);

        // Write requests never accepted
        req = 1'b1; wr = 1'b1; addr = 32'h0000_2000; size = 2'd2; arready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wr_arvalid", arvalid, 1'b0);
            chk("wr_addr_ok", addr_ok, 1'b0);
            chk("wr_data_ok", data_ok, 1'b0);
        end
        req = 1'b0; wr = 1'b0; arready = 1'b0;
        tick();

        // Asynchronous reset while in ADDR
        req = 1'b1; addr = 32'h0000_3000; size = 2'd2;
        tick();
        req = 1'b0; #1;
        chk("rstmid_arvalid_before", arvalid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_arvalid_async", arvalid, 1'b0);
        chk("rstmid_araddr_async",  araddr,  32'h0);
        chk("rstmid_arsize_async",  arsize,  3'b000);
        tick();
        rst = 1'b0;
        tick();
        req = 1'b1; addr = 32'h0000_0040; size = 2'd2; arready = 1'b1;
        tick();
        req = 1'b0; #1;
        chk("post_rst_araddr",  araddr,  32'h0000_0040);
        chk("post_rst_addr_ok", addr_ok, 1'b1);
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h1234_5678; #1;
        chk("post_rst_data_ok", data_ok, 1'b1);
        chk("post_rst_rdata",   rdata,   32'h1234_5678);
        tick();
        rvalid = 1'b0;

`ifdef INST_AXI_RD_BRIDGE_RRESP_ERR_EN
        // Error response: flagged, data still returned, sticky until reset
        #1;
        chk("err_seen_initial", err_seen, 1'b0);
        req = 1'b1; addr = 32'h0000_0080; size = 2'd2; arready = 1'b1;
        tick();
        req = 1'b0;
        tick();
        arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata_axi = 32'hCAFE_0001; #1;
        chk("err_data_ok", data_ok, 1'b1);
        chk("err_bus_err", bus_err, 1'b1);
        chk("err_rdata",   rdata,   32'hCAFE_0001);
        tick();
        rvalid = 1'b0; rresp = 2'b00; #1;
        chk("err_bus_err_pulse", bus_err, 1'b0);
        chk("err_seen_set", err_seen, 1'b1);
        req = 1'b1; addr = 32'h0000_0084; arready = 1'b1;
        tick();
        req = 1'b0;
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata_axi = 32'h0000_0002; #1;
        chk("ok_data_ok", data_ok, 1'b1);
        chk("ok_bus_err", bus_err, 1'b0);
        tick();
        rvalid = 1'b0; #1;
        chk("err_seen_sticky", err_seen, 1'b1);
        rst = 1'b1; #1;
        chk("err_seen_cleared", err_seen, 1'b0);
        tick();
        rst = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
